// File: rtl/pool_pkg.sv
// pool_pkg: window/mode encodings and accumulator-width helper shared by pool_unit and its reducers
package pool_pkg;
    typedef enum logic [1:0] {WIN_1 = 2'd0, WIN_2 = 2'd1, WIN_4 = 2'd2, WIN_8 = 2'd3} win_e;
    typedef enum logic {MODE_AVG = 1'b0, MODE_MAX = 1'b1} mode_e;
    localparam int SUM_GUARD = 3;
    function automatic int sum_w(input int dwidth);
        return dwidth + SUM_GUARD;
    endfunction
endpackage

// File: rtl/pool_if.sv
// pool_if: row stream, pooling config and tile status between the array output path and pool_unit
interface pool_if #(
    parameter int DWIDTH = 16,
    parameter int LANES = 32,
    parameter int ROWS_PER_TILE = 32
);
    logic                                 enable_pool;
    logic [1:0]                           win_sel;
    logic                                 pool_mode;
    logic                                 in_valid;
    logic                                 in_ready;
    logic [LANES*DWIDTH-1:0]              in_data;
    logic [LANES-1:0]                     in_mask;
    logic                                 out_valid;
    logic                                 out_ready;
    logic [LANES*DWIDTH-1:0]              out_data;
    logic [LANES-1:0]                     out_mask;
    logic                                 done_pool;
    logic [$clog2(ROWS_PER_TILE+1)-1:0]   row_count;
    modport master (
        output enable_pool, win_sel, pool_mode, in_valid, in_data, in_mask, out_ready,
        input  in_ready, out_valid, out_data, out_mask, done_pool, row_count
    );
    modport slave (
        input  enable_pool, win_sel, pool_mode, in_valid, in_data, in_mask, out_ready,
        output in_ready, out_valid, out_data, out_mask, done_pool, row_count
    );
endinterface

// File: rtl/pool_group_reduce.sv
// pool_group_reduce: sum (and, with POOL_MAX_MODE_EN, max) trees over one 8-lane group, selected by window
module pool_group_reduce
    import pool_pkg::*;
#(
    parameter int DWIDTH = 16
) (
    input  logic [8*DWIDTH-1:0] i_data,
    input  logic [7:0]          i_mask,
    input  logic [1:0]          i_win_sel,
    input  logic                i_mode,
    output logic [8*DWIDTH-1:0] o_data,
    output logic [7:0]          o_mask
);
    localparam int SW = sum_w(DWIDTH);
    logic [SW-1:0]     w_s0 [8];
    logic [SW-1:0]     w_s1 [4];
    logic [SW-1:0]     w_s2 [2];
    logic [SW-1:0]     w_s3;
    logic [3:0]        w_m1;
    logic [1:0]        w_m2;
    logic              w_m3;
    logic [DWIDTH-1:0] w_r0 [8];
    logic [DWIDTH-1:0] w_r1 [4];
    logic [DWIDTH-1:0] w_r2 [2];
    logic [DWIDTH-1:0] w_r3;

    // divisor is always the window size, so masked lanes just pull the average down
    function automatic logic [DWIDTH-1:0] avg(input logic [SW-1:0] s, input int sh);
        return DWIDTH'(s >> sh);
    endfunction

    always_comb begin
        for (int j = 0; j < 8; j++) w_s0[j] = i_mask[j] ? SW'(i_data[j*DWIDTH +: DWIDTH]) : '0;
        for (int j = 0; j < 4; j++) begin
            w_s1[j] = w_s0[2*j] + w_s0[2*j+1];
            w_m1[j] = |i_mask[2*j +: 2];
        end
        for (int j = 0; j < 2; j++) begin
            w_s2[j] = w_s1[2*j] + w_s1[2*j+1];
            w_m2[j] = |w_m1[2*j +: 2];
        end
        w_s3 = w_s2[0] + w_s2[1];
        w_m3 = |w_m2;
    end

`ifdef POOL_MAX_MODE_EN
    logic [DWIDTH-1:0] w_x0 [8];
    logic [DWIDTH-1:0] w_x1 [4];
    logic [DWIDTH-1:0] w_x2 [2];
    logic [DWIDTH-1:0] w_x3;

    function automatic logic [DWIDTH-1:0] mx(input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b);
        return a > b ? a : b;
    endfunction

    // masked lanes enter as 0, which never wins an unsigned compare against a real element
    always_comb begin
        for (int j = 0; j < 8; j++) w_x0[j] = i_mask[j] ? i_data[j*DWIDTH +: DWIDTH] : '0;
        for (int j = 0; j < 4; j++) w_x1[j] = mx(w_x0[2*j], w_x0[2*j+1]);
        for (int j = 0; j < 2; j++) w_x2[j] = mx(w_x1[2*j], w_x1[2*j+1]);
        w_x3 = mx(w_x2[0], w_x2[1]);
        for (int j = 0; j < 8; j++) w_r0[j] = i_mode == MODE_MAX ? w_x0[j] : avg(w_s0[j], 0);
        for (int j = 0; j < 4; j++) w_r1[j] = i_mode == MODE_MAX ? w_x1[j] : avg(w_s1[j], 1);
        for (int j = 0; j < 2; j++) w_r2[j] = i_mode == MODE_MAX ? w_x2[j] : avg(w_s2[j], 2);
        w_r3 = i_mode == MODE_MAX ? w_x3 : avg(w_s3, 3);
    end
`else
    logic w_unused_mode;
    assign w_unused_mode = i_mode;

    always_comb begin
        for (int j = 0; j < 8; j++) w_r0[j] = avg(w_s0[j], 0);
        for (int j = 0; j < 4; j++) w_r1[j] = avg(w_s1[j], 1);
        for (int j = 0; j < 2; j++) w_r2[j] = avg(w_s2[j], 2);
        w_r3 = avg(w_s3, 3);
    end
`endif

    always_comb begin
        o_data = '0;
        o_mask = '0;
        for (int j = 0; j < 8; j++) if (i_win_sel == WIN_1) begin
            o_data[j*DWIDTH +: DWIDTH] = w_r0[j];
            o_mask[j] = i_mask[j];
        end
        for (int j = 0; j < 4; j++) if (i_win_sel == WIN_2) begin
            o_data[j*DWIDTH +: DWIDTH] = w_r1[j];
            o_mask[j] = w_m1[j];
        end
        for (int j = 0; j < 2; j++) if (i_win_sel == WIN_4) begin
            o_data[j*DWIDTH +: DWIDTH] = w_r2[j];
            o_mask[j] = w_m2[j];
        end
        if (i_win_sel == WIN_8) begin
            o_data[DWIDTH-1:0] = w_r3;
            o_mask[0] = w_m3;
        end
    end
endmodule

// File: rtl/pool_unit.sv
// pool_unit: two-stage valid/ready horizontal pooling with tile counting; max-pooling only when POOL_MAX_MODE_EN is defined
module pool_unit
    import pool_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int LANES = 32,
    parameter int ROWS_PER_TILE = 32
) (
    input logic   clk,
    input logic   reset,
    pool_if.slave bus
);
    localparam int CW = $clog2(ROWS_PER_TILE + 1);
    logic                    r_s1_valid;
    logic [LANES*DWIDTH-1:0] r_s1_data;
    logic [LANES-1:0]        r_s1_mask;
    logic [1:0]              r_s1_ws;
    logic                    r_s1_mode;
    logic                    r_s1_en;
    logic                    r_out_valid;
    logic [LANES*DWIDTH-1:0] r_out_data;
    logic [LANES-1:0]        r_out_mask;
    logic [CW-1:0]           r_cnt;
    logic                    r_done;
    logic                    w_stall;
    logic                    w_in_ready;
    logic                    w_in_fire;
    logic                    w_out_fire;
    logic [LANES*DWIDTH-1:0] w_gd;
    logic [LANES-1:0]        w_gm;
    logic [LANES*DWIDTH-1:0] w_red_data;
    logic [LANES-1:0]        w_red_mask;

    // group results are packed at the front of each 8-lane group; gather them into consecutive output lanes
    function automatic int src_lane(input int k, input int ws);
        return ((k >> (3 - ws)) << 3) + (k & ((8 >> ws) - 1));
    endfunction

    assign w_stall    = r_out_valid && !bus.out_ready;
    assign w_in_ready = !reset && (!r_s1_valid || !w_stall);
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_out_fire = r_out_valid && bus.out_ready;

    for (genvar g = 0; g < LANES / 8; g++) begin : g_grp
        pool_group_reduce #(.DWIDTH(DWIDTH)) u_red (
            .i_data   (r_s1_data[g*8*DWIDTH +: 8*DWIDTH]),
            .i_mask   (r_s1_mask[g*8 +: 8]),
            .i_win_sel(r_s1_ws),
            .i_mode   (r_s1_mode),
            .o_data   (w_gd[g*8*DWIDTH +: 8*DWIDTH]),
            .o_mask   (w_gm[g*8 +: 8])
        );
    end

    always_comb begin
        w_red_data = '0;
        w_red_mask = '0;
        for (int k = 0; k < LANES; k++) if (k < (LANES >> r_s1_ws)) begin
            w_red_data[k*DWIDTH +: DWIDTH] = w_gd[src_lane(k, int'(r_s1_ws))*DWIDTH +: DWIDTH];
            w_red_mask[k] = w_gm[src_lane(k, int'(r_s1_ws))];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_s1_mask   <= '0;
            r_s1_ws     <= WIN_1;
            r_s1_mode   <= MODE_AVG;
            r_s1_en     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_mask  <= '0;
        end else begin
            r_s1_valid <= w_in_fire || (r_s1_valid && w_stall);
            if (w_in_fire) begin
                r_s1_data <= bus.in_data;
                r_s1_mask <= bus.in_mask;
                r_s1_ws   <= bus.win_sel;
                r_s1_mode <= bus.pool_mode;
                r_s1_en   <= bus.enable_pool;
            end
            if (!w_stall) r_out_valid <= r_s1_valid;
            if (!w_stall && r_s1_valid) begin
                r_out_data <= r_s1_en ? w_red_data : r_s1_data;
                r_out_mask <= r_s1_en ? w_red_mask : r_s1_mask;
            end
        end
    end

    // counter follows the live enable so a disabled unit never carries a partial tile forward
    always_ff @(posedge clk) begin
        if (reset || !bus.enable_pool) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (w_out_fire) begin
            r_done <= r_cnt == CW'(ROWS_PER_TILE - 1);
            r_cnt  <= r_cnt == CW'(ROWS_PER_TILE - 1) ? '0 : r_cnt + 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_mask  = r_out_mask;
    assign bus.done_pool = !reset && (r_done || !bus.enable_pool);
    assign bus.row_count = r_cnt;
endmodule

// File: tb/tb_pool_unit.sv
// tb_pool_unit: directed and random rows through pool_unit against an arithmetic reference model
module tb_pool_unit;
    localparam int DW = 16;
    localparam int L = 32;
    localparam int RPT = 32;
    localparam int LW = DW * L;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pool_if #(.DWIDTH(DW), .LANES(L), .ROWS_PER_TILE(RPT)) bus ();
    pool_unit #(.DWIDTH(DW), .LANES(L), .ROWS_PER_TILE(RPT)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_fail = 0;
    logic [LW-1:0] q_d[$];
    logic [L-1:0]  q_m[$];
    int            exp_cnt;
    bit            exp_done;
    bit            prev_stall;
    bit            last_fire;
    logic [LW-1:0] held_d;
    logic [L-1:0]  held_m;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference: plain integer average (divide by W) or max over each window of the row
    function automatic void ref_row(input logic [LW-1:0] d, input logic [L-1:0] m, input int ws,
                                    input bit mode, input bit en,
                                    output logic [LW-1:0] od, output logic [L-1:0] om);
        int w;
        int sum;
        int mxv;
        int e;
        logic [31:0] v;
        od = '0;
        om = '0;
        if (!en) begin
            od = d;
            om = m;
            return;
        end
        w = 1 << ws;
        for (int k = 0; k < L / w; k++) begin
            sum = 0;
            mxv = 0;
            for (int i = 0; i < w; i++) begin
                e = int'(d[(k*w+i)*DW +: DW]);
                if (m[k*w+i]) begin
                    sum += e;
                    om[k] = 1'b1;
                    if (e > mxv) mxv = e;
                end
            end
            v = 32'(sum / w);
`ifdef POOL_MAX_MODE_EN
            if (mode) v = 32'(mxv);
`endif
            od[k*DW +: DW] = v[DW-1:0];
        end
    endfunction

    function automatic logic [LW-1:0] rnd_data();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic step(input bit v, input logic [LW-1:0] d, input logic [L-1:0] m, input logic [1:0] ws,
                        input bit mode, input bit en, input bit ordy);
        logic [LW-1:0] ed;
        logic [L-1:0]  em;
        bit ofire;
        bit ifire;
        bus.in_valid = v;
        bus.in_data = d;
        bus.in_mask = m;
        bus.win_sel = ws;
        bus.pool_mode = mode;
        bus.enable_pool = en;
        bus.out_ready = ordy;
        #1;
        if (prev_stall) begin
            chk("stall_valid", bus.out_valid, 1'b1);
            chk("stall_data", bus.out_data, held_d);
            chk("stall_mask", bus.out_mask, held_m);
        end
        chk("row_count", bus.row_count, exp_cnt);
        chk("done_pool", bus.done_pool, !en || exp_done);
        ofire = bus.out_valid && ordy;
        ifire = v && bus.in_ready;
        if (ofire) begin
            chk("sb_has_row", q_d.size() > 0, 1'b1);
            if (q_d.size() > 0) begin
                ed = q_d.pop_front();
                em = q_m.pop_front();
                chk("out_data", bus.out_data, ed);
                chk("out_mask", bus.out_mask, em);
            end
        end
        if (ifire) begin
            ref_row(d, m, int'(ws), mode, en, ed, em);
            q_d.push_back(ed);
            q_m.push_back(em);
        end
        last_fire = ifire;
        if (!en) begin
            exp_cnt = 0;
            exp_done = 1'b0;
        end else if (ofire) begin
            exp_cnt = (exp_cnt + 1) % RPT;
            exp_done = exp_cnt == 0;
        end
        prev_stall = bus.out_valid && !ordy;
        held_d = bus.out_data;
        held_m = bus.out_mask;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.in_mask = '0;
        bus.win_sel = 2'd0;
        bus.pool_mode = 1'b0;
        bus.enable_pool = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, '0);
        chk("rst_out_mask", bus.out_mask, '0);
        chk("rst_done", bus.done_pool, 1'b0);
        chk("rst_row_count", bus.row_count, '0);
        reset = 1'b0;
        q_d.delete();
        q_m.delete();
        exp_cnt = 0;
        exp_done = 1'b0;
        prev_stall = 1'b0;
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1'b1);
    endtask

    task automatic drain(input bit en);
        for (int i = 0; i < 20 && q_d.size() > 0; i++) step(1'b0, '0, '0, 2'd0, 1'b0, en, 1'b1);
        chk("drain_empty", q_d.size(), 0);
    endtask

    task automatic pair(input logic [LW-1:0] d, input logic [L-1:0] m, input logic [1:0] ws,
                        input bit mode, input bit en);
        step(1'b1, d, m, ws, mode, en, 1'b1);
        chk("lat_one_edge", bus.out_valid, 1'b0);
        step(1'b0, d, m, ws, mode, en, 1'b1);
        chk("lat_two_edges", bus.out_valid, 1'b1);
    endtask

    initial begin
        logic [LW-1:0] d;
        logic [L-1:0]  m;
        int n;
        do_reset();

        d = rnd_data();
        d[15:0] = 16'd10;
        d[31:16] = 16'd13;
        m = '1;
        pair(d, m, 2'd1, 1'b0, 1'b1);
        chk("avg_w2_lane0", bus.out_data[15:0], 16'd11);
        chk("avg_w2_mask0", bus.out_mask[0], 1'b1);
        chk("avg_w2_hi_data", bus.out_data[LW-1:LW/2], '0);
        chk("avg_w2_hi_mask", bus.out_mask[L-1:L/2], '0);
        drain(1'b1);

        for (int i = 0; i < L; i++) d[i*DW +: DW] = 16'd8;
        m = '1;
        m[3] = 1'b0;
        pair(d, m, 2'd3, 1'b0, 1'b1);
        chk("avg_w8_lane0", bus.out_data[15:0], 16'd7);
        chk("avg_w8_mask0", bus.out_mask[0], 1'b1);
        drain(1'b1);

        d = rnd_data();
        d[15:0] = 16'd5;
        d[31:16] = 16'hFFFF;
        d[47:32] = 16'd2;
        d[63:48] = 16'd9;
        m = '1;
        m[1] = 1'b0;
        pair(d, m, 2'd2, 1'b1, 1'b1);
`ifdef POOL_MAX_MODE_EN
        chk("max_w4_lane0", bus.out_data[15:0], 16'd9);
`else
        chk("mode_ignored_w4_lane0", bus.out_data[15:0], 16'd4);
`endif
        drain(1'b1);

        d = rnd_data();
        m = L'($urandom);
        pair(d, m, 2'd2, 1'b0, 1'b0);
        chk("pass_data", bus.out_data, d);
        chk("pass_mask", bus.out_mask, m);
        chk("pass_done", bus.done_pool, 1'b1);
        drain(1'b0);

        n = 0;
        repeat (5) begin
            step(1'b1, rnd_data(), L'($urandom), 2'($urandom_range(0, 3)), 1'b0, 1'b1, 1'b0);
            n += int'(last_fire);
        end
        chk("bp_accepts", n, 2);
        drain(1'b1);

        do_reset();
        repeat (RPT) step(1'b1, rnd_data(), '1, 2'd1, 1'b0, 1'b1, 1'b1);
        drain(1'b1);
        chk("tile_done", bus.done_pool, 1'b1);
        chk("tile_wrap", bus.row_count, 0);
        step(1'b1, rnd_data(), '1, 2'd1, 1'b0, 1'b1, 1'b1);
        drain(1'b1);
        chk("after_done_drop", bus.done_pool, 1'b0);
        chk("after_done_cnt", bus.row_count, 1);

        repeat (10) step(1'b1, rnd_data(), '1, 2'd0, 1'b0, 1'b1, 1'b1);
        do_reset();

        repeat (800) step($urandom_range(0, 9) < 7, rnd_data(), L'($urandom | $urandom),
                          2'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 9) != 0,
                          $urandom_range(0, 9) < 7);
        drain(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
